wavetable_oscillator: RTL and testbench
=======================================

Name: wavetable_oscillator

Overview:
- Sample source feeding the DAC stage directly. It produces one 12-bit unsigned, offset-binary sample per sample period.
- Each sample comes with a single-cycle ready strobe that connects to the DAC's inSample/inSampleReady inputs.
- Generation uses a phase accumulator, a selectable waveform (saw/square/triangle/sine) and 8-bit amplitude scaling.
- The sample rate comes from an internal clock divider.

Parameters:
- SAMPLE_DIV, 1134, system clocks per sample period (50 MHz / 1134 ≈ 44.09 kHz); legal range ≥ 8.
- PHASE_W, 24, phase accumulator width; output frequency = inPhaseInc * Fs / 2^PHASE_W.

Ports:
- inClk  input  1  system clock, all logic on rising edge.
- inReset  input  1  synchronous, active-high reset.
- inPhaseInc  input  PHASE_W  phase increment per sample.
- inWaveSel  input  2  0 = saw, 1 = square, 2 = triangle, 3 = sine.
- inAmplitude  input  8  gain, 0..255, applied as value/256.
- inGate  input  1  1 = oscillate; 0 = hold phase at 0, output midscale.
- outSample  output  12  unsigned offset-binary sample (2048 = zero).
- outSampleReady  output  1  one-cycle pulse; outSample is valid and newly updated in that cycle.

Behaviour:
- One clock (inClk). Reset is synchronous, active-high, and clears all state. Reset values: outSample = 2048, outSampleReady = 0, divider = 0, phase = 0, pipeline valids = 0.
- Divider:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick = 1 in the cycle where count = SAMPLE_DIV-1.
  - First tick occurs SAMPLE_DIV-1 cycles after reset deasserts.
- Stage 1 (on tick):
  - If inGate = 1: phase <= phase + inPhaseInc, mod 2^PHASE_W; wrap is silent.
  - If inGate = 0: phase <= 0.
  - inPhaseInc, inWaveSel, inAmplitude and inGate are sampled only on the tick. They are registered alongside phase so that changes between ticks have no effect.
- Stage 2 (registered): compute signed 12-bit s, range -2048..2047, from u = phase[PHASE_W-1 -: 12].
  - saw: s = u - 2048.
  - square: s = +2047 if u[11] = 0, else -2048.
  - triangle: t = u[11] ? ~{u[10:0],1'b0} : {u[10:0],1'b0}; s = t - 2048.
  - sine:
    - Quarter-wave LUT of 256 entries × 11 bits; LUT[i] = round(2047*sin((i+0.5)*π/512)).
    - idx = u[10] ? ~u[9:2] : u[9:2].
    - mag = LUT[idx]; s = u[11] ? -mag : mag.
    - The LUT read is registered in this stage.
  - Gate sampled low: s = 0.
- Stage 3 (registered): p = s * inAmplitude (20-bit signed); y = p >>> 8 (arithmetic shift, floor); out = y + 2048, truncated to 12 bits. No overflow is possible.
- Stage 4: outSample <= out; outSampleReady <= 1 for exactly one cycle.
- Latency: the ready pulse comes 3 cycles after the tick cycle. Pulse spacing is exactly SAMPLE_DIV cycles.
- outSample changes only in ready-pulse cycles and is held between them.
- Gate low: pulses continue and carry 2048, so the DAC keeps refreshing.
- Reset mid-pipeline: in-flight samples are discarded. No ready pulse is emitted until a new tick has propagated.
- Pipeline never stalls; there is no back-pressure from the DAC. The DAC must accept one sample per SAMPLE_DIV cycles.

Decomposition:
- Package synth_pkg:
  - PHASE_W, SAMPLE_W = 12, MIDSCALE = 12'd2048.
  - Wave-select constants WAVE_SAW/SQUARE/TRI/SINE.
  - Signed sample typedef.
- Sub-module sine_quarter_lut:
  - 8-bit address in, registered 11-bit magnitude out, one-cycle latency.
  - ROM contents generated from the formula above.

Test Plan:
1. Reset and divider timing:
   - Stimulus: hold inReset 3 cycles, then release.
   - Required: outSample = 2048 and ready = 0 during reset. First ready pulse SAMPLE_DIV+2 cycles after release; subsequent pulses every SAMPLE_DIV cycles.
2. Saw:
   - Stimulus: inc = 0x100000, amp = 255, gate = 1.
   - Required: first sample 263 (s = -1792 → -1785). Samples step by 256 in s, and the 16th sample wraps back to phase 0.
3. Square:
   - Stimulus: inc = 0x100000, amp = 128.
   - Required: samples 1–7 = 3071 (2047*128 >>> 8 = 1023). Sample 8 (u = 0x800) = 1024 (-2048*128 >>> 8 = -1024). Period = 16 samples.
4. Sine:
   - Stimulus: inc = 0x400000, amp = 255.
   - Required: sample 1 = 4087 (idx 255, mag 2047 → 2039). Sample 2 = 2042 (idx 0, mag 6, negated → -6).
5. Gate and parameter sampling:
   - Stimulus: drop gate mid-stream; change inc between ticks.
   - Required: gate low → next pulse carries 2048 and phase returns to 0; raising the gate restarts from phase = inc. An inc change is applied only at the next tick.
6. Reset mid-pipeline:
   - Stimulus: assert inReset the cycle after a tick.
   - Required: no ready pulse for that sample; outSample = 2048; next pulse SAMPLE_DIV+2 cycles after release.

Source files
------------

// File: rtl/synth_pkg.sv
// synth_pkg: shared constants, types and sine ROM generator for the wavetable oscillator
package synth_pkg;
    localparam int PHASE_W = 24;
    localparam int SAMPLE_W = 12;
    localparam logic [SAMPLE_W-1:0] MIDSCALE = 12'd2048;
    typedef enum logic [1:0] {
        WAVE_SAW    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SINE   = 2'd3
    } wave_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
    // round(2047*sin((i+0.5)*pi/512)) by a Q28 fixed-point Taylor series, evaluated at elaboration
    function automatic logic [10:0] sineEntry(input int i);
        longint x, x2, term, acc;
        x = (longint'(2 * i + 1) * 843314857) / 1024;
        x2 = (x * x) >>> 28;
        term = x;
        acc = x;
        for (int k = 1; k < 8; k++) begin
            term = -((term * x2) >>> 28) / ((2 * k) * (2 * k + 1));
            acc += term;
        end
        return 11'((acc * 2047 + (longint'(1) <<< 27)) >>> 28);
    endfunction
endpackage

// File: rtl/wavetable_oscillator_if.sv
// wavetable_oscillator_if: control inputs and DAC sample link of the oscillator
//   master: oscillator side (controls in, sample/ready out); slave: controller/DAC side
interface wavetable_oscillator_if #(
    parameter int PHASE_W = synth_pkg::PHASE_W
);
    import synth_pkg::*;
    logic [PHASE_W-1:0]  inPhaseInc;
    logic [1:0]          inWaveSel;
    logic [7:0]          inAmplitude;
    logic                inGate;
    logic [SAMPLE_W-1:0] outSample;
    logic                outSampleReady;
    modport master (
        input  inPhaseInc, inWaveSel, inAmplitude, inGate,
        output outSample, outSampleReady
    );
    modport slave (
        output inPhaseInc, inWaveSel, inAmplitude, inGate,
        input  outSample, outSampleReady
    );
endinterface

// File: rtl/sine_quarter_lut.sv
// sine_quarter_lut: 256 x 11-bit quarter-wave sine magnitude ROM, registered read
//   inClk: clock; inAddr: quarter-wave index; outMag: magnitude, one cycle after inAddr
module sine_quarter_lut (
    input  logic        inClk,
    input  logic [7:0]  inAddr,
    output logic [10:0] outMag
);
    import synth_pkg::*;
    logic [10:0] rom [256];
    for (genvar i = 0; i < 256; i++) begin : gRom
        localparam logic [10:0] ENTRY = sineEntry(i);
        assign rom[i] = ENTRY;
    end
    always_ff @(posedge inClk) outMag <= rom[inAddr];
endmodule

// File: rtl/wavetable_oscillator.sv
// wavetable_oscillator: phase-accumulator sample source for the DAC, one sample per SAMPLE_DIV clocks
//   inClk/inReset: system clock, synchronous active-high reset
//   bus (master):  inPhaseInc/inWaveSel/inAmplitude/inGate in, outSample/outSampleReady out
module wavetable_oscillator #(
    parameter int SAMPLE_DIV = 1134,
    parameter int PHASE_W    = synth_pkg::PHASE_W
) (
    input logic inClk,
    input logic inReset,
    wavetable_oscillator_if.master bus
);
    import synth_pkg::*;
    localparam int CNT_W = $clog2(SAMPLE_DIV);
    logic [CNT_W-1:0]   count;
    logic               tick;
    logic [PHASE_W-1:0] phase;
    wave_t              wave1;
    logic [7:0]         amp1, amp2, lutIdx;
    logic               gate1, v1, v2, isSine2, neg2;
    logic [11:0]        u, triVal, outNext;
    logic [10:0]        mag;
    sample_t            sNext, s2, sFinal;
    logic signed [19:0] p;
    assign tick = count == CNT_W'(SAMPLE_DIV - 1);
    assign u = phase[PHASE_W-1 -: 12];
    assign triVal = u[11] ? ~{u[10:0], 1'b0} : {u[10:0], 1'b0};
    assign lutIdx = u[10] ? ~u[9:2] : u[9:2];
    // sine is resolved one stage later, once the registered LUT magnitude is available
    assign sNext = !gate1 ? '0
                 : wave1 == WAVE_SAW    ? sample_t'(u - MIDSCALE)
                 : wave1 == WAVE_SQUARE ? (u[11] ? 12'sh800 : 12'sh7FF)
                 : wave1 == WAVE_TRI    ? sample_t'(triVal - MIDSCALE)
                 : '0;
    assign sFinal = isSine2 ? (neg2 ? -sample_t'({1'b0, mag}) : sample_t'({1'b0, mag})) : s2;
    assign p = 20'(sFinal) * 20'($signed({1'b0, amp2}));
    assign outNext = 12'(p >>> 8) + MIDSCALE;
    sine_quarter_lut lut (
        .inClk (inClk),
        .inAddr(lutIdx),
        .outMag(mag)
    );
    always_ff @(posedge inClk) begin
        if (inReset) begin
            count <= '0;
            phase <= '0;
            wave1 <= WAVE_SAW;
            amp1 <= '0;
            gate1 <= 1'b0;
            v1 <= 1'b0;
        end else begin
            count <= tick ? '0 : count + CNT_W'(1);
            v1 <= tick;
            if (tick) begin
                phase <= bus.inGate ? phase + bus.inPhaseInc : '0;
                wave1 <= wave_t'(bus.inWaveSel);
                amp1 <= bus.inAmplitude;
                gate1 <= bus.inGate;
            end
        end
    end
    always_ff @(posedge inClk) begin
        if (inReset) begin
            s2 <= '0;
            isSine2 <= 1'b0;
            neg2 <= 1'b0;
            amp2 <= '0;
            v2 <= 1'b0;
        end else begin
            s2 <= sNext;
            isSine2 <= gate1 && wave1 == WAVE_SINE;
            neg2 <= u[11];
            amp2 <= amp1;
            v2 <= v1;
        end
    end
    always_ff @(posedge inClk) begin
        if (inReset) begin
            bus.outSample <= MIDSCALE;
            bus.outSampleReady <= 1'b0;
        end else begin
            bus.outSampleReady <= v2;
            if (v2) bus.outSample <= outNext;
        end
    end
endmodule

// File: tb/tb_wavetable_oscillator.sv
// tb_wavetable_oscillator: directed self-checking bench for wavetable_oscillator
module tb_wavetable_oscillator;
    import synth_pkg::*;
    localparam int DIV = 1134;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    wavetable_oscillator_if #(.PHASE_W(24)) bus ();
    wavetable_oscillator #(.SAMPLE_DIV(DIV), .PHASE_W(24)) dut (
        .inClk  (clk),
        .inReset(rst),
        .bus    (bus)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic waitReady(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.outSampleReady !== 1'b1 && n < 2 * DIV + 8);
    endtask
    task automatic sample(input string tag, input int expGap, input int expVal);
        int n;
        waitReady(n);
        chk({tag, " gap"}, 32'(n), 32'(expGap));
        chk(tag, 32'(bus.outSample), 32'(expVal));
    endtask
    initial begin
        bus.inPhaseInc = 24'h100000;
        bus.inWaveSel = WAVE_SAW;
        bus.inAmplitude = 8'd255;
        bus.inGate = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("reset sample", 32'(bus.outSample), 2048);
        chk("reset ready", 32'(bus.outSampleReady), 0);
        rst = 1'b0;
        sample("saw 1", DIV + 2, 263);
        @(posedge clk);
        #1;
        chk("ready width", 32'(bus.outSampleReady), 0);
        chk("sample hold", 32'(bus.outSample), 263);
        sample("saw 2", DIV - 1, 518);
        for (int k = 3; k <= 16; k++)
            sample($sformatf("saw %0d", k), DIV, 2048 + 255 * ((k % 16) - 8));
        bus.inWaveSel = WAVE_SQUARE;
        bus.inAmplitude = 8'd128;
        for (int k = 1; k <= 16; k++)
            sample($sformatf("square %0d", k), DIV, (k % 16) < 8 ? 3071 : 1024);
        bus.inWaveSel = WAVE_SINE;
        bus.inAmplitude = 8'd255;
        bus.inPhaseInc = 24'h400000;
        sample("sine 1", DIV, 4087);
        sample("sine 2", DIV, 2042);
        sample("sine 3", DIV, 8);
        sample("sine 4", DIV, 2053);
        bus.inWaveSel = WAVE_TRI;
        bus.inPhaseInc = 24'h100000;
        sample("tri 1", DIV, 518);
        sample("tri 2", DIV, 1028);
        bus.inPhaseInc = 24'h700000;
        sample("tri falling", DIV, 3577);
        bus.inGate = 1'b0;
        sample("gate low 1", DIV, 2048);
        bus.inWaveSel = WAVE_SINE;
        sample("gate low 2", DIV, 2048);
        bus.inGate = 1'b1;
        bus.inWaveSel = WAVE_SAW;
        bus.inPhaseInc = 24'h100000;
        sample("gate restart", DIV, 263);
        repeat (DIV - 2) @(posedge clk);
        #1;
        bus.inAmplitude = 8'd0;
        bus.inWaveSel = WAVE_SQUARE;
        bus.inPhaseInc = 24'h300000;
        sample("in-flight params", 2, 518);
        sample("new params", DIV, 2048);
        bus.inAmplitude = 8'd255;
        bus.inWaveSel = WAVE_SAW;
        bus.inPhaseInc = 24'h100000;
        sample("pre-reset", DIV, 1538);
        repeat (DIV - 3) @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid reset sample", 32'(bus.outSample), 2048);
        chk("mid reset ready", 32'(bus.outSampleReady), 0);
        rst = 1'b0;
        sample("after reset", DIV + 2, 263);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
